cd_tx_ram_mp: RTL
=================

// Module: cd_tx_ram_mp
// PURPOSE
//  Multi-page TX frame buffer; the N-page successor of the 2-page ping-pong TX RAM.
//  Host writes a frame into its current page, then commits it with 'switch'; tx engine reads pages in FIFO order.
//  Adds: parametrised page count/size, pending-page count, full flag, commit-reject pulse, synchronous flush.
//  Sits between host register interface (write side) and cd_tx_frame (read side).
// PARAMETERS
//  P_WIDTH  2  log2(page count); PAGES = 2^P_WIDTH (>=2, i.e. P_WIDTH>=1)
//  A_WIDTH  8  log2(bytes per page); 8 -> 256-byte pages
// PORTS
//  clk         in   1        system clock, single domain
//  reset_n     in   1        asynchronous, active-low reset
//  rd_byte     out  8        read data, valid 1 cycle after rd_en
//  rd_addr     in   A_WIDTH  byte offset within current read page
//  rd_en       in   1        read strobe
//  rd_done     in   1        1-cycle pulse: current read page consumed, release it
//  unread      out  1        >=1 committed page waiting (pending != 0)
//  pending     out  P_WIDTH+1  number of committed, unreleased pages
//  full        out  1        pending == PAGES-1; next switch will be rejected
//  wr_byte     in   8        write data
//  wr_addr     in   A_WIDTH  byte offset within current write page
//  wr_en       in   1        write strobe
//  switch      in   1        1-cycle pulse: commit current write page
//  switch_err  out  1        1-cycle pulse: switch rejected because full
//  flush       in   1        1-cycle pulse: discard all pages, return to reset state
// BEHAVIOUR
//  - State: wr_ptr, rd_ptr (P_WIDTH bits, wrap mod PAGES), cnt (P_WIDTH+1 bits); no other FSM.
//  - Reset (async) and flush (sync): wr_ptr=rd_ptr=0, cnt=0 -> unread=0, pending=0, full=0, switch_err=0.
//  - Writer always owns page wr_ptr; it is never committed/visible to the reader.
//    Max committed = PAGES-1 (2-page case equals ping-pong: commit only while other page is clean).
//  - RAM address: write {wr_ptr,wr_addr}, read {rd_ptr,rd_addr}; rd_byte registered, latency 1.
//  - Writes into the write page are allowed in all states, including full; committed pages are never overwritten.
//  - rd_byte while cnt==0 is don't-care (reads the stale rd_ptr page).
//  - switch: if cnt<PAGES-1: wr_ptr<=wr_ptr+1, cnt+1; else ignored and switch_err=1 for exactly that next cycle.
//  - rd_done: if cnt!=0: rd_ptr<=rd_ptr+1, cnt-1; if cnt==0 silently ignored.
//  - switch & rd_done same cycle: evaluate both against pre-edge cnt; both accepted -> cnt unchanged, both pointers advance.
//    When full and rd_done is valid, switch is still rejected (no look-ahead).
//  - flush has priority over switch/rd_done in the same cycle; the RAM contents are not cleared.
//  - Outputs unread/pending/full are registered-derived (from cnt), updated the cycle after the event.
//  - Wrap: pointers roll PAGES-1 -> 0 naturally; cnt never exceeds PAGES-1 nor underflows.
//  - rd_en & wr_en same cycle to same address: read returns old data (sdpram read-first).
// STRUCTURE
//  - Sub-module: cd_sdpram #(.A_WIDTH(P_WIDTH+A_WIDTH)), cen=~(rd_en|wr_en), wen=~wr_en.
//  - Pointer/count logic inline; no further sub-modules.
//  - Shared header cd_def.vh: default CD_TX_PAGE_W=2, CD_PAGE_AW=8 constants reused by cd_rx_ram_mp.
// TESTING
//  T1 reset: after reset_n release -> unread=0, pending=0, full=0, switch_err=0.
//  T2 fill: P_WIDTH=2; write page, switch x3 -> pending=3, full=1; 4th switch -> switch_err pulse, pending stays 3.
//  T3 order: write 0xA0/0xB1/0xC2 at addr 0 of 3 pages, commit each; read addr 0, rd_done each -> 0xA0,0xB1,0xC2, then unread=0.
//  T4 simultaneous: pending=1, switch+rd_done same cycle -> pending=1, both ptrs +1; at full, same -> switch_err=1, pending=PAGES-2.
//  T5 wrap: 10 commit/read cycles with byte = index -> data 0..9 in order, no loss across pointer wrap.
//  T6 flush: pending=2, flush with coincident switch -> pending=0, unread=0, next commit reads from page 0.

Source files
------------

// File: rtl/cd_tx_ram_mp_pkg.sv
// Shared constants and types for the multi-page TX frame buffer.
// The page geometry defaults are reused by the matching RX buffer.
package cd_tx_ram_mp_pkg;

  localparam int CD_TX_PAGE_W = 2;
  localparam int CD_PAGE_AW   = 8;
  localparam int BYTE_W       = 8;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/cd_sdpram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
// The chip enable and write enable are both active-low.
module cd_sdpram #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               cen,
  input  logic               wen,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [0:(1<<A_WIDTH)-1];

  // Read samples the old word when the write hits the same address.
  always_ff @(posedge clk) begin
    if (!cen) begin
      rd_data <= mem[rd_addr];
      if (!wen) mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/cd_tx_ram_mp.sv
// Multi-page TX frame buffer: host fills its private page and commits it with
// switch; the tx engine drains committed pages in FIFO order and frees them with rd_done.
module cd_tx_ram_mp
  import cd_tx_ram_mp_pkg::*;
#(
  parameter int P_WIDTH = CD_TX_PAGE_W,
  parameter int A_WIDTH = CD_PAGE_AW
) (
  input  logic               clk,
  input  logic               reset_n,
  output byte_t              rd_byte,
  input  logic [A_WIDTH-1:0] rd_addr,
  input  logic               rd_en,
  input  logic               rd_done,
  output logic               unread,
  output logic [P_WIDTH:0]   pending,
  output logic               full,
  input  byte_t              wr_byte,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic               wr_en,
  input  logic               switch,
  output logic               switch_err,
  input  logic               flush
);

  localparam int               PAGES   = 1 << P_WIDTH;
  localparam logic [P_WIDTH:0] CNT_MAX = (P_WIDTH+1)'(PAGES - 1);
  localparam logic [P_WIDTH:0] CNT_ONE = (P_WIDTH+1)'(1);
  localparam logic [P_WIDTH-1:0] PTR_ONE = P_WIDTH'(1);

  logic [P_WIDTH-1:0] wr_ptr;
  logic [P_WIDTH-1:0] rd_ptr;
  logic [P_WIDTH:0]   cnt;
  logic               sw_ok;
  logic               rd_ok;

  // Both requests are judged on the pre-edge count, so a full buffer rejects
  // switch even when a page is released in the same cycle.
  assign sw_ok = switch && (cnt < CNT_MAX);
  assign rd_ok = rd_done && (cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      switch_err <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      switch_err <= 1'b0;
    end else begin
      switch_err <= switch && !sw_ok;
      if (sw_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      if (sw_ok && !rd_ok)      cnt <= cnt + CNT_ONE;
      else if (!sw_ok && rd_ok) cnt <= cnt - CNT_ONE;
    end
  end

  assign pending = cnt;
  assign unread  = (cnt != '0);
  assign full    = (cnt == CNT_MAX);

  // Stage p1: page pointer forms the upper address bits on each port.
  cd_sdpram #(
    .A_WIDTH (P_WIDTH + A_WIDTH),
    .D_WIDTH (BYTE_W)
  ) u_ram (
    .clk     (clk),
    .cen     (~(rd_en | wr_en)),
    .wen     (~wr_en),
    .wr_addr ({wr_ptr, wr_addr}),
    .wr_data (wr_byte),
    .rd_addr ({rd_ptr, rd_addr}),
    .rd_data (rd_byte)
  );

endmodule
